// File: rtl/mem_arb_pkg.sv
// Shared codes for the memory port arbiter: FSM states, owner ids, write sizes.
package mem_arb_pkg;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_RD_WAIT  = 2'd1;
  localparam logic [1:0] ST_WR_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP_ERR = 2'd3;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_IF   = 2'd1;
  localparam logic [1:0] OWN_D    = 2'd2;
  localparam logic [1:0] OWN_DBG  = 2'd3;

  localparam logic [1:0] WS_READ = 2'd0;
  localparam logic [1:0] WS_BYTE = 2'd1;
  localparam logic [1:0] WS_HALF = 2'd2;
  localparam logic [1:0] WS_WORD = 2'd3;

  // Halves need an even address, words a multiple of four; bytes and reads always pass.
  function automatic logic wr_misaligned(input logic [1:0] wsize, input logic [1:0] a_lo);
    case (wsize)
      WS_HALF: wr_misaligned = a_lo[0];
      WS_WORD: wr_misaligned = |a_lo;
      default: wr_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester handshakes and memory-side signals around the arbiter.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // instruction fetch
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              if_err;
  // load/store
  logic              d_req;
  logic [ADDR_W-1:0] d_addr;
  logic [1:0]        d_wsize;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              d_err;
  // debug reader
  logic              dbg_req;
  logic [ADDR_W-1:0] dbg_addr;
  logic              dbg_rvalid;
  logic [DATA_W-1:0] dbg_rdata;
  // memory
  logic [ADDR_W-1:0] mem_address;
  logic [1:0]        mem_write;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_done;
  logic              mem_error;
  // status
  logic              busy;
  logic [1:0]        owner;

  // Requesters and memory drive from this side.
  modport master (
    output if_req, if_addr, d_req, d_addr, d_wsize, d_wdata, dbg_req, dbg_addr,
           mem_rdata, mem_done, mem_error,
    input  if_gnt, if_rvalid, if_rdata, if_err, d_gnt, d_rvalid, d_rdata, d_err,
           dbg_rvalid, dbg_rdata, mem_address, mem_write, mem_wdata, busy, owner
  );

  // The arbiter itself.
  modport slave (
    input  if_req, if_addr, d_req, d_addr, d_wsize, d_wdata, dbg_req, dbg_addr,
           mem_rdata, mem_done, mem_error,
    output if_gnt, if_rvalid, if_rdata, if_err, d_gnt, d_rvalid, d_rdata, d_err,
           dbg_rvalid, dbg_rdata, mem_address, mem_write, mem_wdata, busy, owner
  );
endinterface

// File: rtl/mem_arb_timer.sv
// Loadable down-counter; o_expired is high while the count sits at zero.
module mem_arb_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_val,
  output logic             o_expired
);
  logic [CNT_W-1:0] r_cnt;

  // Load wins over counting; the count parks at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               r_cnt <= '0;
    else if (i_load)       r_cnt <= i_val;
    else if (r_cnt != '0)  r_cnt <= r_cnt - 1'b1;
  end

  assign o_expired = (r_cnt == '0);
endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: D > IF > DBG, one transaction in flight,
// handshake-based completion with write timeout and alignment checking.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 2,
  parameter int WR_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  bus
);
  localparam int MAXC  = (RD_LAT > WR_TIMEOUT) ? RD_LAT : WR_TIMEOUT;
  localparam int CNT_W = $clog2(MAXC + 1);
  // Read waits RD_LAT+1 cycles in total (count hits zero on the last one).
  localparam logic [CNT_W-1:0] LD_RD  = CNT_W'(RD_LAT);
  localparam logic [CNT_W-1:0] LD_WR  = CNT_W'(WR_TIMEOUT - 1);
  // Error response is held two cycles so it never arrives sooner than the fastest real access.
  localparam logic [CNT_W-1:0] LD_ERR = CNT_W'(1);

  logic [1:0]        r_state;
  logic [1:0]        r_owner;
  logic              r_quiet;
  logic              r_err_acc;
  logic [ADDR_W-1:0] r_mem_address;
  logic [1:0]        r_mem_write;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_if_gnt, r_if_rvalid, r_if_err;
  logic              r_d_gnt, r_d_rvalid, r_d_err;
  logic              r_dbg_rvalid;
  logic [DATA_W-1:0] r_if_rdata, r_d_rdata, r_dbg_rdata;

  logic              w_idle, w_d_win, w_if_win, w_dbg_win, w_d_wr, w_d_mis, w_load, w_exp;
  logic [CNT_W-1:0]  w_load_val;

  assign w_idle    = (r_state == ST_IDLE);
  assign w_d_win   = w_idle & bus.d_req;
  assign w_if_win  = w_idle & ~bus.d_req & bus.if_req;
  assign w_dbg_win = w_idle & ~bus.d_req & ~bus.if_req & bus.dbg_req & r_quiet;
  assign w_d_wr    = (bus.d_wsize != WS_READ);
  assign w_d_mis   = wr_misaligned(bus.d_wsize, bus.d_addr[1:0]);
  assign w_load    = w_d_win | w_if_win | w_dbg_win;

  // Pick the timer reload for the transaction being granted.
  always_comb begin
    w_load_val = LD_RD;
    if (w_d_win && w_d_wr) w_load_val = w_d_mis ? LD_ERR : LD_WR;
  end

  mem_arb_timer #(.CNT_W(CNT_W)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_load),
    .i_val     (w_load_val),
    .o_expired (w_exp)
  );

  // DBG may only take the port after IF and D have both been quiet for a full cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_quiet <= 1'b0;
    else     r_quiet <= ~bus.if_req & ~bus.d_req;
  end

  // Transaction FSM: grant, wait on read latency / write done / timeout, deliver response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_owner       <= OWN_NONE;
      r_err_acc     <= 1'b0;
      r_mem_address <= '0;
      r_mem_write   <= WS_READ;
      r_mem_wdata   <= '0;
      r_if_gnt      <= 1'b0;
      r_if_rvalid   <= 1'b0;
      r_if_err      <= 1'b0;
      r_d_gnt       <= 1'b0;
      r_d_rvalid    <= 1'b0;
      r_d_err       <= 1'b0;
      r_dbg_rvalid  <= 1'b0;
      r_if_rdata    <= '0;
      r_d_rdata     <= '0;
      r_dbg_rdata   <= '0;
    end else begin
      r_if_gnt     <= 1'b0;
      r_d_gnt      <= 1'b0;
      r_if_rvalid  <= 1'b0;
      r_if_err     <= 1'b0;
      r_d_rvalid   <= 1'b0;
      r_d_err      <= 1'b0;
      r_dbg_rvalid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_err_acc <= 1'b0;
          if (w_d_win) begin
            r_d_gnt       <= 1'b1;
            r_owner       <= OWN_D;
            r_mem_address <= bus.d_addr;
            r_mem_wdata   <= w_d_wr ? bus.d_wdata : '0;
            if (!w_d_wr) begin
              r_state     <= ST_RD_WAIT;
              r_mem_write <= WS_READ;
            end else if (w_d_mis) begin
              r_state     <= ST_RESP_ERR;
              r_mem_write <= WS_READ;
            end else begin
              r_state     <= ST_WR_WAIT;
              r_mem_write <= bus.d_wsize;
            end
          end else if (w_if_win) begin
            r_if_gnt      <= 1'b1;
            r_owner       <= OWN_IF;
            r_mem_address <= bus.if_addr;
            r_mem_wdata   <= '0;
            r_mem_write   <= WS_READ;
            r_state       <= ST_RD_WAIT;
          end else if (w_dbg_win) begin
            r_owner       <= OWN_DBG;
            r_mem_address <= bus.dbg_addr;
            r_mem_wdata   <= '0;
            r_mem_write   <= WS_READ;
            r_state       <= ST_RD_WAIT;
          end
        end
        ST_RD_WAIT: begin
          r_err_acc <= r_err_acc | bus.mem_error;
          if (w_exp) begin
            case (r_owner)
              OWN_IF: begin
                r_if_rdata  <= bus.mem_rdata;
                r_if_rvalid <= 1'b1;
                r_if_err    <= r_err_acc | bus.mem_error;
              end
              OWN_D: begin
                r_d_rdata  <= bus.mem_rdata;
                r_d_rvalid <= 1'b1;
                r_d_err    <= r_err_acc | bus.mem_error;
              end
              default: begin
                r_dbg_rdata  <= bus.mem_rdata;
                r_dbg_rvalid <= 1'b1;
              end
            endcase
            r_owner <= OWN_NONE;
            r_state <= ST_IDLE;
          end
        end
        ST_WR_WAIT: begin
          if (bus.mem_done) begin
            r_mem_write <= WS_READ;
            r_d_rvalid  <= 1'b1;
            r_d_err     <= bus.mem_error;
            r_owner     <= OWN_NONE;
            r_state     <= ST_IDLE;
          end else if (w_exp) begin
            r_mem_write <= WS_READ;
            r_d_rvalid  <= 1'b1;
            r_d_err     <= 1'b1;
            r_owner     <= OWN_NONE;
            r_state     <= ST_IDLE;
          end
        end
        ST_RESP_ERR: begin
          if (w_exp) begin
            r_d_rvalid <= 1'b1;
            r_d_err    <= 1'b1;
            r_owner    <= OWN_NONE;
            r_state    <= ST_IDLE;
          end
        end
        default: begin
          r_mem_write <= WS_READ;
          r_owner     <= OWN_NONE;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.if_gnt      = r_if_gnt;
  assign bus.if_rvalid   = r_if_rvalid;
  assign bus.if_rdata    = r_if_rdata;
  assign bus.if_err      = r_if_err;
  assign bus.d_gnt       = r_d_gnt;
  assign bus.d_rvalid    = r_d_rvalid;
  assign bus.d_rdata     = r_d_rdata;
  assign bus.d_err       = r_d_err;
  assign bus.dbg_rvalid  = r_dbg_rvalid;
  assign bus.dbg_rdata   = r_dbg_rdata;
  assign bus.mem_address = r_mem_address;
  assign bus.mem_write   = r_mem_write;
  assign bus.mem_wdata   = r_mem_wdata;
  assign bus.busy        = ~w_idle;
  assign bus.owner       = r_owner;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, reads, priority, alignment, timeout, debug, abort.
module tb_mem_port_arbiter;
  logic clk;
  logic rst;
  int   errors;
  int   checks;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(2), .WR_TIMEOUT(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one cycle; inputs change and outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (bus.owner !== 2'd0) begin errors++; $display("FAIL reset_owner got=%0d exp=0", bus.owner); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", bus.busy); end
    checks++; if (bus.mem_write !== 2'd0) begin errors++; $display("FAIL reset_mem_write got=%0d exp=0", bus.mem_write); end
    checks++; if ({bus.if_rdata, bus.d_rdata, bus.dbg_rdata} !== 96'd0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", {bus.if_rdata, bus.d_rdata, bus.dbg_rdata}); end
    checks++; if ({bus.if_gnt, bus.d_gnt, bus.if_rvalid, bus.d_rvalid, bus.dbg_rvalid} !== 5'd0) begin errors++; $display("FAIL reset_strobes got=%b exp=0", {bus.if_gnt, bus.d_gnt, bus.if_rvalid, bus.d_rvalid, bus.dbg_rvalid}); end
    rst = 1'b0;
    tick();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy got=%0b exp=0", bus.busy); end
  endtask

  // IF read of 0x10: gnt c0, rvalid c3
  task automatic test_if_read();
    bus.mem_rdata = 32'h0000_0013;
    bus.if_addr   = 32'h0000_0010;
    bus.if_req    = 1'b1;
    tick();
    checks++; if (bus.if_gnt !== 1'b1) begin errors++; $display("FAIL if_gnt got=%0b exp=1", bus.if_gnt); end
    checks++; if (bus.mem_address !== 32'h10) begin errors++; $display("FAIL if_addr got=%h exp=00000010", bus.mem_address); end
    checks++; if (bus.owner !== 2'd1 || bus.busy !== 1'b1) begin errors++; $display("FAIL if_owner got=%0d/%0b exp=1/1", bus.owner, bus.busy); end
    bus.if_req = 1'b0;
    tick();
    checks++; if (bus.if_rvalid !== 1'b0 || bus.if_gnt !== 1'b0) begin errors++; $display("FAIL if_c1 got=%0b%0b exp=00", bus.if_rvalid, bus.if_gnt); end
    tick();
    checks++; if (bus.if_rvalid !== 1'b0) begin errors++; $display("FAIL if_c2_rvalid got=%0b exp=0", bus.if_rvalid); end
    tick();
    checks++; if (bus.if_rvalid !== 1'b1 || bus.if_err !== 1'b0) begin errors++; $display("FAIL if_c3_rvalid got=%0b err=%0b exp=1 err=0", bus.if_rvalid, bus.if_err); end
    checks++; if (bus.if_rdata !== 32'h13) begin errors++; $display("FAIL if_rdata got=%h exp=00000013", bus.if_rdata); end
    checks++; if (bus.owner !== 2'd0 || bus.busy !== 1'b0) begin errors++; $display("FAIL if_done_idle got=%0d/%0b exp=0/0", bus.owner, bus.busy); end
  endtask

  // IF and D together: D write first, IF served the cycle after d_rvalid
  task automatic test_priority();
    bus.if_addr = 32'h0000_0040;
    bus.if_req  = 1'b1;
    bus.d_addr  = 32'h0000_0020;
    bus.d_wsize = 2'd3;
    bus.d_wdata = 32'hDEAD_BEEF;
    bus.d_req   = 1'b1;
    tick();
    checks++; if (bus.d_gnt !== 1'b1 || bus.if_gnt !== 1'b0) begin errors++; $display("FAIL prio_gnt got d=%0b if=%0b exp d=1 if=0", bus.d_gnt, bus.if_gnt); end
    checks++; if (bus.mem_write !== 2'd3 || bus.mem_wdata !== 32'hDEAD_BEEF || bus.mem_address !== 32'h20) begin errors++; $display("FAIL prio_mem got wr=%0d wd=%h a=%h exp 3 deadbeef 20", bus.mem_write, bus.mem_wdata, bus.mem_address); end
    bus.d_req = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++; if (bus.mem_write !== 2'd3 || bus.if_gnt !== 1'b0 || bus.d_rvalid !== 1'b0) begin errors++; $display("FAIL prio_hold c%0d got wr=%0d ifg=%0b dv=%0b exp 3 0 0", k, bus.mem_write, bus.if_gnt, bus.d_rvalid); end
    end
    bus.mem_done = 1'b1;
    tick();
    bus.mem_done = 1'b0;
    checks++; if (bus.d_rvalid !== 1'b1 || bus.d_err !== 1'b0) begin errors++; $display("FAIL prio_wr_resp got v=%0b e=%0b exp v=1 e=0", bus.d_rvalid, bus.d_err); end
    checks++; if (bus.mem_write !== 2'd0 || bus.if_gnt !== 1'b0) begin errors++; $display("FAIL prio_wr_done got wr=%0d ifg=%0b exp 0 0", bus.mem_write, bus.if_gnt); end
    bus.mem_rdata = 32'hCAFE_0001;
    tick();
    checks++; if (bus.if_gnt !== 1'b1 || bus.mem_address !== 32'h40) begin errors++; $display("FAIL prio_if_gnt got g=%0b a=%h exp g=1 a=00000040", bus.if_gnt, bus.mem_address); end
    bus.if_req = 1'b0;
    tick(); tick(); tick();
    checks++; if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== 32'hCAFE_0001) begin errors++; $display("FAIL prio_if_resp got v=%0b d=%h exp v=1 d=cafe0001", bus.if_rvalid, bus.if_rdata); end
  endtask

  // misaligned half write: error 2 cycles after gnt, memory never written
  task automatic test_misaligned();
    bus.d_addr  = 32'h0000_0003;
    bus.d_wsize = 2'd2;
    bus.d_wdata = 32'h1234_5678;
    bus.d_req   = 1'b1;
    tick();
    checks++; if (bus.d_gnt !== 1'b1 || bus.mem_write !== 2'd0) begin errors++; $display("FAIL mis_gnt got g=%0b wr=%0d exp g=1 wr=0", bus.d_gnt, bus.mem_write); end
    bus.d_req = 1'b0;
    tick();
    checks++; if (bus.d_rvalid !== 1'b0 || bus.mem_write !== 2'd0) begin errors++; $display("FAIL mis_c1 got v=%0b wr=%0d exp v=0 wr=0", bus.d_rvalid, bus.mem_write); end
    tick();
    checks++; if (bus.d_rvalid !== 1'b1 || bus.d_err !== 1'b1 || bus.mem_write !== 2'd0) begin errors++; $display("FAIL mis_resp got v=%0b e=%0b wr=%0d exp 1 1 0", bus.d_rvalid, bus.d_err, bus.mem_write); end
    tick();
  endtask

  // byte write, mem_done never comes: timeout 15 cycles after gnt
  task automatic test_timeout();
    bus.d_addr  = 32'h0000_0031;
    bus.d_wsize = 2'd1;
    bus.d_wdata = 32'h0000_00AB;
    bus.d_req   = 1'b1;
    tick();
    checks++; if (bus.d_gnt !== 1'b1 || bus.mem_write !== 2'd1) begin errors++; $display("FAIL to_gnt got g=%0b wr=%0d exp g=1 wr=1", bus.d_gnt, bus.mem_write); end
    bus.d_req = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      tick();
      checks++; if (bus.mem_write !== 2'd1 || bus.d_rvalid !== 1'b0) begin errors++; $display("FAIL to_wait c%0d got wr=%0d v=%0b exp wr=1 v=0", k, bus.mem_write, bus.d_rvalid); end
    end
    tick();
    checks++; if (bus.d_rvalid !== 1'b1 || bus.d_err !== 1'b1 || bus.mem_write !== 2'd0) begin errors++; $display("FAIL to_resp got v=%0b e=%0b wr=%0d exp 1 1 0", bus.d_rvalid, bus.d_err, bus.mem_write); end
    tick();
  endtask

  // D read (reads not alignment-checked) with a one-cycle mem_error mid-wait
  task automatic test_d_read_err();
    bus.mem_rdata = 32'h0BAD_F00D;
    bus.d_addr    = 32'h0000_0003;
    bus.d_wsize   = 2'd0;
    bus.d_req     = 1'b1;
    tick();
    bus.d_req     = 1'b0;
    bus.mem_error = 1'b1;
    tick();
    bus.mem_error = 1'b0;
    tick(); tick();
    checks++; if (bus.d_rvalid !== 1'b1 || bus.d_err !== 1'b1 || bus.d_rdata !== 32'h0BAD_F00D) begin errors++; $display("FAIL drd_resp got v=%0b e=%0b d=%h exp 1 1 0badf00d", bus.d_rvalid, bus.d_err, bus.d_rdata); end
    tick();
  endtask

  // DBG held off by a fetch that was just withdrawn; served after one quiet cycle
  task automatic test_dbg();
    bus.mem_rdata = 32'h1111_2222;
    bus.if_addr   = 32'h0000_0008;
    bus.if_req    = 1'b1;
    bus.dbg_addr  = 32'h0000_0100;
    bus.dbg_req   = 1'b1;
    tick();
    checks++; if (bus.if_gnt !== 1'b1 || bus.owner !== 2'd1) begin errors++; $display("FAIL dbg_if_first got g=%0b o=%0d exp g=1 o=1", bus.if_gnt, bus.owner); end
    bus.if_req = 1'b0;
    tick();
    tick();
    bus.if_req = 1'b1;
    tick();
    checks++; if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== 32'h1111_2222) begin errors++; $display("FAIL dbg_if_resp got v=%0b d=%h exp 1 11112222", bus.if_rvalid, bus.if_rdata); end
    bus.if_req    = 1'b0;
    bus.mem_rdata = 32'h5A5A_A5A5;
    tick();
    checks++; if (bus.owner !== 2'd0 || bus.busy !== 1'b0) begin errors++; $display("FAIL dbg_quiet_gap got o=%0d b=%0b exp 0 0", bus.owner, bus.busy); end
    tick();
    checks++; if (bus.owner !== 2'd3 || bus.busy !== 1'b1 || bus.mem_address !== 32'h100) begin errors++; $display("FAIL dbg_gnt got o=%0d b=%0b a=%h exp 3 1 00000100", bus.owner, bus.busy, bus.mem_address); end
    tick(); tick(); tick();
    checks++; if (bus.dbg_rvalid !== 1'b1 || bus.dbg_rdata !== 32'h5A5A_A5A5) begin errors++; $display("FAIL dbg_resp got v=%0b d=%h exp 1 5a5aa5a5", bus.dbg_rvalid, bus.dbg_rdata); end
    bus.dbg_req = 1'b0;
    tick();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL dbg_release got b=%0b exp 0", bus.busy); end
  endtask

  // reset during WR_WAIT aborts with no response
  task automatic test_reset_abort();
    bus.d_addr  = 32'h0000_0044;
    bus.d_wsize = 2'd3;
    bus.d_wdata = 32'hA5A5_5A5A;
    bus.d_req   = 1'b1;
    tick();
    bus.d_req = 1'b0;
    tick();
    checks++; if (bus.mem_write !== 2'd3) begin errors++; $display("FAIL abort_pre got wr=%0d exp 3", bus.mem_write); end
    rst = 1'b1;
    tick();
    checks++; if (bus.owner !== 2'd0 || bus.mem_write !== 2'd0 || bus.busy !== 1'b0) begin errors++; $display("FAIL abort_state got o=%0d wr=%0d b=%0b exp 0 0 0", bus.owner, bus.mem_write, bus.busy); end
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (bus.d_rvalid !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL abort_quiet c%0d got v=%0b b=%0b exp 0 0", k, bus.d_rvalid, bus.busy); end
    end
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    rst           = 1'b1;
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.d_req     = 1'b0;
    bus.d_addr    = '0;
    bus.d_wsize   = 2'd0;
    bus.d_wdata   = '0;
    bus.dbg_req   = 1'b0;
    bus.dbg_addr  = '0;
    bus.mem_rdata = '0;
    bus.mem_done  = 1'b0;
    bus.mem_error = 1'b0;
    test_reset();
    test_if_read();
    tick();
    test_priority();
    tick();
    test_misaligned();
    test_timeout();
    test_d_read_err();
    tick();
    test_dbg();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
